freq_div_multi: RTL and testbench

Programmable multi-channel clock-enable / divided-clock generator for slow timebases such as 1 Hz, 1 kHz and blink rates. Each of NCH channels has its own divisor and output mode, runtime-reprogrammable through a single write port. Updates are glitch-free and take effect only at a period boundary. Feeds LED, display-scan and debounce logic from the one system clock. No derived clock is used as a clock elsewhere.

---
 rtl/freq_div_multi_if.sv | 28 ++
 rtl/freq_div_multi.sv | 128 ++++++++++++
 tb/tb_freq_div_multi.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/freq_div_multi_if.sv
// Control/status bundle of the multi-channel divider: run enables, the
// divisor write port and the per-channel divided outputs.
interface freq_div_multi_if #(
  parameter int CNT_W = 32,
  parameter int NCH   = 4
) ();
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]   en;
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [CNT_W-1:0] wr_div;
  logic             wr_mode;
  logic             wr_ack;
  logic             wr_err;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;

  modport master (
    output en, wr_en, wr_ch, wr_div, wr_mode,
    input  wr_ack, wr_err, clk_out, tick
  );

  modport slave (
    input  en, wr_en, wr_ch, wr_div, wr_mode,
    output wr_ack, wr_err, clk_out, tick
  );
endinterface

// File: rtl/freq_div_multi.sv
// Multi-channel programmable clock-enable / divided-clock generator; divisor
// and mode updates are held pending and applied only at a period boundary.
module freq_div_multi #(
  parameter int CNT_W   = 32,
  parameter int NCH     = 4,
  parameter int DEF_DIV = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  freq_div_multi_if.slave   bus
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic [CNT_W-1:0] cnt_q  [NCH];
  logic [CNT_W-1:0] cnt_d  [NCH];
  logic [CNT_W-1:0] div_q  [NCH];
  logic [CNT_W-1:0] div_d  [NCH];
  logic [CNT_W-1:0] pdiv_q [NCH];
  logic [CNT_W-1:0] pdiv_d [NCH];
  logic [NCH-1:0]   mode_q, mode_d;
  logic [NCH-1:0]   pmode_q, pmode_d;
  logic [NCH-1:0]   pend_q, pend_d;
  logic [NCH-1:0]   clk_out_q, clk_out_d;
  logic [NCH-1:0]   tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             ch_ok;
  logic             wr_ok;

  // With a power-of-two channel count every select value is a real channel.
  if (NCH == (1 << CH_W)) begin : g_ch_full
    assign ch_ok = 1'b1;
  end else begin : g_ch_part
    assign ch_ok = (int'(bus.wr_ch) < NCH);
  end

  assign wr_ok = bus.wr_en & ch_ok & (bus.wr_div >= CNT_W'(2));

  // Next-state: counting, period-boundary apply and pending-write capture.
  always_comb begin
    ack_d = bus.wr_en & wr_ok;
    err_d = bus.wr_en & ~wr_ok;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i]     = cnt_q[i];
      div_d[i]     = div_q[i];
      mode_d[i]    = mode_q[i];
      pdiv_d[i]    = pdiv_q[i];
      pmode_d[i]   = pmode_q[i];
      pend_d[i]    = pend_q[i];
      clk_out_d[i] = clk_out_q[i];
      tick_d[i]    = 1'b0;
      if (bus.en[i]) begin
        // cnt_q is (n-1) mod D for the edge being taken.
        tick_d[i] = (cnt_q[i] == div_q[i] - CNT_W'(1));
        if (mode_q[i]) begin
          clk_out_d[i] = tick_d[i];
        end else begin
          clk_out_d[i] = (cnt_q[i] < ((div_q[i] >> 1) + {{(CNT_W-1){1'b0}}, div_q[i][0]}));
        end
        if (tick_d[i]) begin
          cnt_d[i] = '0;
          if (pend_q[i]) begin
            div_d[i]  = pdiv_q[i];
            mode_d[i] = pmode_q[i];
            pend_d[i] = 1'b0;
          end else begin
            pend_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else if (pend_q[i]) begin
        cnt_d[i]     = '0;
        div_d[i]     = pdiv_q[i];
        mode_d[i]    = pmode_q[i];
        pend_d[i]    = 1'b0;
        clk_out_d[i] = 1'b0;
      end else begin
        // Square output holds while stalled; a pulse output is only ever a tick.
        clk_out_d[i] = clk_out_q[i] & ~mode_q[i];
      end
      if (wr_ok && (bus.wr_ch == CH_W'(i))) begin
        pdiv_d[i]  = bus.wr_div;
        pmode_d[i] = bus.wr_mode;
        pend_d[i]  = 1'b1;
      end else begin
        pdiv_d[i]  = pdiv_d[i];
        pmode_d[i] = pmode_d[i];
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= '0;
        div_q[i]  <= CNT_W'(DEF_DIV);
        pdiv_q[i] <= CNT_W'(DEF_DIV);
      end
      mode_q    <= '0;
      pmode_q   <= '0;
      pend_q    <= '0;
      clk_out_q <= '0;
      tick_q    <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        div_q[i]  <= div_d[i];
        pdiv_q[i] <= pdiv_d[i];
      end
      mode_q    <= mode_d;
      pmode_q   <= pmode_d;
      pend_q    <= pend_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  assign bus.clk_out = clk_out_q;
  assign bus.tick    = tick_q;
  assign bus.wr_ack  = ack_q;
  assign bus.wr_err  = err_q;
endmodule

// File: tb/tb_freq_div_multi.sv
// Directed plus randomized bench for freq_div_multi against an enabled-edge
// counting reference model.
module tb_freq_div_multi;
  localparam int CNT_W = 8;
  localparam int NCH   = 4;
  localparam int DEFD  = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  int       m_n  [NCH];
  int       m_d  [NCH];
  int       m_pd [NCH];
  bit       m_mode [NCH];
  bit       m_pm   [NCH];
  bit       m_pend [NCH];
  bit [NCH-1:0] e_clk, e_tick;
  bit       e_ack, e_err;

  freq_div_multi_if #(.CNT_W(CNT_W), .NCH(NCH)) bus ();
  freq_div_multi #(.CNT_W(CNT_W), .NCH(NCH), .DEF_DIV(DEFD)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_n[i] = 0; m_d[i] = DEFD; m_pd[i] = DEFD;
      m_mode[i] = 1'b0; m_pm[i] = 1'b0; m_pend[i] = 1'b0;
    end
    e_clk = '0; e_tick = '0; e_ack = 1'b0; e_err = 1'b0;
  endtask

  // One rising edge of the reference: n counts enabled edges since the last apply.
  task automatic model_edge();
    bit valid;
    int ch;
    for (int i = 0; i < NCH; i++) begin
      if (bus.en[i]) begin
        m_n[i]++;
        e_tick[i] = (m_n[i] % m_d[i] == 0);
        e_clk[i]  = m_mode[i] ? e_tick[i] : (((m_n[i] - 1) % m_d[i]) < (m_d[i] + 1) / 2);
        if (e_tick[i] && m_pend[i]) begin
          m_d[i] = m_pd[i]; m_mode[i] = m_pm[i]; m_pend[i] = 1'b0; m_n[i] = 0;
        end
      end else begin
        e_tick[i] = 1'b0;
        if (m_pend[i]) begin
          m_d[i] = m_pd[i]; m_mode[i] = m_pm[i]; m_pend[i] = 1'b0; m_n[i] = 0;
          e_clk[i] = 1'b0;
        end else if (m_mode[i]) begin
          e_clk[i] = 1'b0;
        end
      end
    end
    ch    = int'(bus.wr_ch);
    valid = (ch < NCH) && (int'(bus.wr_div) >= 2);
    e_ack = bus.wr_en && valid;
    e_err = bus.wr_en && !valid;
    if (e_ack) begin
      m_pd[ch] = int'(bus.wr_div); m_pm[ch] = bus.wr_mode; m_pend[ch] = 1'b1;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".clk_out"}, 32'(bus.clk_out), 32'(e_clk));
    check({tag, ".tick"},    32'(bus.tick),    32'(e_tick));
    check({tag, ".wr_ack"},  32'(bus.wr_ack),  32'(e_ack));
    check({tag, ".wr_err"},  32'(bus.wr_err),  32'(e_err));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic steps(input string tag, input int n);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  task automatic wr(input string tag, input int ch, input int div, input bit mode);
    bus.wr_en = 1'b1; bus.wr_ch = 2'(ch); bus.wr_div = 8'(div); bus.wr_mode = mode;
    step(tag);
    bus.wr_en = 1'b0;
  endtask

  initial begin
    int hi_cnt;
    int tick_seen;
    bus.en = '0; bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_div = '0; bus.wr_mode = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    rst = 1'b0;

    // 1: channel 0 at default D=10, 5 high / 5 low, tick every 10 edges.
    bus.en = 4'b0001;
    hi_cnt = 0; tick_seen = 0;
    for (int k = 1; k <= 30; k++) begin
      step("t1");
      if (bus.clk_out[0]) hi_cnt++;
      if (bus.tick[0]) tick_seen++;
    end
    check("t1.high_cycles", 32'(hi_cnt), 32'd15);
    check("t1.ticks", 32'(tick_seen), 32'd3);

    // 2: program ch2 while idle, then run it: 4 high / 3 low.
    bus.en = 4'b0000;
    step("t2.idle");
    wr("t2.wr", 2, 7, 1'b0);
    check("t2.ack_seen", 32'(bus.wr_ack), 32'd1);
    step("t2.apply");
    bus.en = 4'b0100;
    hi_cnt = 0;
    for (int k = 1; k <= 7; k++) begin
      step("t2.run");
      if (bus.clk_out[2]) hi_cnt++;
    end
    check("t2.high_cycles", 32'(hi_cnt), 32'd4);
    check("t2.tick_edge7", 32'(bus.tick[2]), 32'd1);
    steps("t2.run2", 14);

    // 3: ch1 at D=10, reprogram to pulse D=4 at enabled edge 3.
    bus.en = 4'b0110;
    steps("t3.pre", 2);
    wr("t3.wr", 1, 4, 1'b1);
    steps("t3.run", 25);

    // 4: rejected writes leave ch0 on D=10.
    bus.en = 4'b0000;
    wr("t4.div1", 0, 1, 1'b1);
    check("t4.err1", 32'(bus.wr_err), 32'd1);
    wr("t4.div0", 3, 0, 1'b0);
    check("t4.err2", 32'(bus.wr_err), 32'd1);
    bus.en = 4'b0001;
    steps("t4.run", 12);

    // 5: stall ch0 for 3 edges after its enabled edge 6.
    for (int k = 0; k < 20 && (m_n[0] % m_d[0]) != 6; k++) step("t5.align");
    check("t5.aligned", 32'(m_n[0] % m_d[0]), 32'd6);
    bus.en = 4'b0000;
    steps("t5.stall", 3);
    bus.en = 4'b0001;
    steps("t5.resume", 3);
    check("t5.no_tick_yet", 32'(bus.tick[0]), 32'd0);
    step("t5.edge10");
    check("t5.tick_4th", 32'(bus.tick[0]), 32'd1);

    // Random phase: enables, valid/invalid writes, overlaps with wraps.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(7) == 0) bus.en = 4'($urandom);
      if ($urandom_range(4) == 0) begin
        bus.wr_en = 1'b1; bus.wr_ch = 2'($urandom);
        bus.wr_div = ($urandom_range(9) == 0) ? 8'($urandom_range(1)) : 8'($urandom_range(12, 2));
        bus.wr_mode = 1'($urandom);
      end else begin
        bus.wr_en = 1'b0;
      end
      step("rand");
    end
    bus.wr_en = 1'b0;

    // 6: asynchronous reset between edges clears outputs before the next edge.
    bus.en = 4'b1111;
    steps("t6.pre", 5);
    #3;
    rst = 1'b1;
    #1;
    check("t6.async_clk_out", 32'(bus.clk_out), 32'd0);
    check("t6.async_tick", 32'(bus.tick), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    compare_all("t6.held");
    rst = 1'b0;
    steps("t6.run", 25);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
